dmem_banked_ctrl: RTL
=====================

// Module: dmem_banked_ctrl
// PURPOSE
//  Parametrised, handshaked successor to the datapath's single-cycle data memory: a single-port
//  word RAM with byte-enable writes, registered 1-cycle reads, out-of-range error signalling and
//  a hardware init sweep after reset. It sits in the MEM stage and stalls the pipeline via
//  req_ready while initialising or while a response is back-pressured.
// PARAMETERS
//  DATA_W  16  data word width in bits; multiple of 8
//  ADDR_W  16  request address width (word address)
//  DEPTH   16  number of words; valid addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W
//  BE_W    DATA_W/8  derived localparam, byte-enable width
// PORTS
//  clk        in   1       clock; all state changes on posedge
//  rst        in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid && req_ready
//  req_write  in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  req_be     in   BE_W    byte enables (writes only); bit k covers bits [8k+7:8k]
//  rsp_valid  out  1       response present (reads and writes both respond)
//  rsp_ready  in   1       response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads
//  rsp_err    out  1       address out of range (or parity fault, see CONFIGURATION)
//  init_busy  out  1       high during the init sweep
//  parity_err out  1       sticky parity fault flag; tied 0 when DMEM_PARITY_EN is undefined
// BEHAVIOUR
//  Reset (rst=0, async): state=INIT, init_cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   parity_err=0, req_ready=0, init_busy=1. Array contents are not reset; the sweep rewrites them.
//  INIT: one word per cycle, word i <= nibble (i==0 ? 4'hA : i[3:0]) replicated DATA_W/4 times
//   (DATA_W=16: 16'hAAAA, 16'h1111, ..., 16'hFFFF, 16'h0000 at 16). After DEPTH cycles -> RUN
//   (init_busy falls on the cycle after the last write). req_ready=0 throughout.
//  RUN: req_ready = !rsp_valid || rsp_ready (zero-bubble streaming).
//  Accepted read: the next cycle has rsp_valid=1 and rsp_rdata=mem[addr]. Latency is exactly 1.
//  Accepted write: bytes with req_be[k]=1 are updated at the accept edge; the next cycle has
//   rsp_valid=1, rsp_rdata=0. be=0 is a legal no-op write that still responds.
//  A read accepted in the cycle after a write to the same address returns the new data.
//  Out of range (addr >= DEPTH): no array access; the response has rsp_err=1 and rsp_rdata=0.
//  Back-pressure: while rsp_valid && !rsp_ready, hold rsp_* stable and keep req_ready=0.
//  Response pops with no new accept: rsp_valid=0 next cycle.
//  Reset mid-operation: any pending response is dropped and the sweep restarts from word 0.
//  Reset mid-INIT: the sweep restarts from word 0.
//  States: INIT -> RUN only (on init_cnt==DEPTH-1). RUN -> INIT only via reset.
// CONFIGURATION
//  DMEM_PARITY_EN defined: the array stores 1 even-parity bit per byte, written with that byte.
//   A read with any byte-parity mismatch sets rsp_err=1 (rsp_rdata still returns raw data) and
//   sets parity_err (sticky until reset). The init sweep writes correct parity.
//  DMEM_PARITY_EN undefined: no parity storage; parity_err=0; rsp_err only for range errors.
// STRUCTURE
//  Package dmem_pkg: state enum {INIT,RUN}; function init_word(idx) returning the sweep pattern;
//   function byte_parity(data) returning BE_W bits.
//  Sub-module dmem_array: storage, byte-enable write port, combinational read, optional parity
//   bits. Control FSM, init counter, response register and range check live in dmem_banked_ctrl.
// TESTING
//  1. Reset then wait: init_busy high for 16 cycles; read addr 0,1,9 -> 16'hAAAA,16'h1111,16'h9999.
//  2. Write addr 3 data 16'hBEEF be=2'b01, then read 3 -> 16'h33EF; write be=2'b10 16'hBEEF,
//     then read -> 16'hBEEF.
//  3. Read addr 16 (DEPTH=16) -> rsp_err=1, rsp_rdata=0; a write to 16 leaves all words unchanged.
//  4. Streaming reads 0..7 with rsp_ready=1 -> 8 responses on 8 consecutive cycles.
//     rsp_ready=0 for 3 cycles -> rsp held and req_ready=0.
//  5. Assert rst during INIT cycle 5 and during a held response -> outputs reset and a full
//     16-cycle sweep follows.
//  6. DMEM_PARITY_EN: force a flipped bit in the array at addr 2, read 2 -> rsp_err=1 and
//     parity_err stays 1 until reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data-memory controller.
// Build option: DMEM_PARITY_EN adds one even-parity bit per stored byte.
package dmem_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int DMEM_MAX_W = 64;

  // Sweep pattern at full width; callers truncate to their DATA_W.
  function automatic logic [DMEM_MAX_W-1:0] init_word(input logic [31:0] idx);
    logic [3:0] nib;
    nib = (idx == 32'd0) ? 4'hA : idx[3:0];
    return {16{nib}};
  endfunction

  function automatic logic [7:0] byte_parity(input logic [DMEM_MAX_W-1:0] data);
    logic [7:0] p;
    for (int k = 0; k < 8; k++) begin
      p[k] = ^data[8*k +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enable writes and combinational read.
// Build option: DMEM_PARITY_EN stores and checks a parity bit per byte.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_par_err
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < BE_W; k++) begin
      if (i_we && i_be[k]) begin
        r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

`ifdef DMEM_PARITY_EN
  logic [BE_W-1:0] r_par [DEPTH];
  logic [BE_W-1:0] w_wpar;
  logic [BE_W-1:0] w_rpar;

  assign w_wpar = BE_W'(byte_parity(DMEM_MAX_W'(i_wdata)));
  assign w_rpar = BE_W'(byte_parity(DMEM_MAX_W'(o_rdata)));

  always_ff @(posedge clk) begin
    for (int k = 0; k < BE_W; k++) begin
      if (i_we && i_be[k]) begin
        r_par[i_addr][k] <= w_wpar[k];
      end
    end
  end

  assign o_par_err = |(w_rpar ^ r_par[i_addr]);
`else
  assign o_par_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Handshaked single-port data memory: init sweep, 1-cycle registered reads, range errors.
// Build option: DMEM_PARITY_EN enables parity fault reporting on reads.
module dmem_banked_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy,
  output logic                parity_err,
  output logic                dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers where rsp_valid && rsp_ready. rsp_* hold while unconsumed.

  localparam int BE_W = DATA_W / 8;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            r_state;
  logic [AW-1:0]     r_init_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_parity_err;

  logic              w_accept;
  logic              w_in_range;
  logic              w_we;
  logic [AW-1:0]     w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic              w_par_err;
  logic              w_rd_perr;

  assign w_in_range = ((ADDR_W+1)'(req_addr) < (ADDR_W+1)'(DEPTH));
  assign req_ready  = (r_state == RUN) && (!r_rsp_valid || rsp_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_rd_perr  = !req_write && w_in_range && w_par_err;

  // The sweep owns the array port during INIT; requests own it in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = req_addr[AW-1:0];
    w_be    = req_be;
    w_wdata = req_wdata;
    if (r_state == INIT) begin
      w_we    = 1'b1;
      w_addr  = r_init_cnt;
      w_be    = '1;
      w_wdata = DATA_W'(init_word(32'(r_init_cnt)));
    end else begin
      w_we    = w_accept && req_write && w_in_range;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_addr    (w_addr),
    .i_be      (w_be),
    .i_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_par_err (w_par_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= INIT;
      r_init_cnt   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_init_cnt == AW'(DEPTH - 1)) begin
            r_state    <= RUN;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + AW'(1);
          end
        end
        RUN: begin
          if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (!req_write && w_in_range) ? w_rdata : '0;
            r_rsp_err   <= !w_in_range || w_rd_perr;
            if (w_rd_perr) begin
              r_parity_err <= 1'b1;
            end
          end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign parity_err = r_parity_err;
  assign init_busy  = (r_state == INIT);
  assign dbg_state  = r_state;

endmodule
